// File: rtl/tdc_readout_sched.sv
// Round-robin readout scheduler for the TDC channel bank: grants one pending channel at a
// time, pushes {channel, timestamp} into a FWFT FIFO and pulses that channel's ack.
module tdc_readout_sched #(
   parameter  int NCHAN  = 4,
   parameter  int TS_W   = 32,
   parameter  int DEPTH  = 8,
   localparam int CHAN_W = $clog2(NCHAN),
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int LVL_W  = $clog2(DEPTH) + 1
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic                    enable_i,
   input  logic [NCHAN-1:0]        ch_valid_i,
   input  logic [NCHAN*TS_W-1:0]   ch_ts_i,
   output logic [NCHAN-1:0]        ch_ack_o,
   input  logic                    rd_en_i,
   output logic [TS_W-1:0]         rd_ts_o,
   output logic [CHAN_W-1:0]       rd_chan_o,
   output logic                    fifo_empty_o,
   output logic                    fifo_full_o,
   output logic [LVL_W-1:0]        fifo_level_o,
   output logic [15:0]             stall_cnt_o,
   output logic                    dbg_state_o
);

   // Handshakes: a channel holds ch_valid_i until it sees its one-cycle ch_ack_o pulse;
   // the host side treats rd_en_i as ready, a word leaves on an edge with rd_en_i && !fifo_empty_o.
   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [CHAN_W-1:0]      last_q;
   logic [NCHAN-1:0]       ack_q, ack_d;
   logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]       level_q;
   logic [15:0]            stall_q;
   logic [CHAN_W+TS_W-1:0] mem [DEPTH];

   logic                   full_w, empty_w, push, pop, stall_inc;
   logic                   found_hi, found_lo;
   logic [CHAN_W-1:0]      winner_hi, winner_lo, winner;
   logic [TS_W-1:0]        win_ts;
   logic [CHAN_W+TS_W-1:0] head;

   assign full_w  = (level_q == LVL_W'(DEPTH));
   assign empty_w = (level_q == '0);
   assign pop     = rd_en_i && !empty_w;

   // Channels above last get priority over those at or below it, giving rotation from last+1.
   always_comb begin
      found_hi  = 1'b0;
      found_lo  = 1'b0;
      winner_hi = '0;
      winner_lo = '0;
      for (int i = 0; i < NCHAN; i++) begin
         if (ch_valid_i[i] && (CHAN_W'(i) > last_q) && !found_hi) begin
            winner_hi = CHAN_W'(i);
            found_hi  = 1'b1;
         end
         if (ch_valid_i[i] && (CHAN_W'(i) <= last_q) && !found_lo) begin
            winner_lo = CHAN_W'(i);
            found_lo  = 1'b1;
         end
      end
      winner = found_hi ? winner_hi : winner_lo;
   end

   always_comb begin
      win_ts = '0;
      ack_d  = '0;
      for (int i = 0; i < NCHAN; i++) begin
         if (winner == CHAN_W'(i)) begin
            win_ts   = ch_ts_i[i*TS_W +: TS_W];
            ack_d[i] = push;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      push      = 1'b0;
      stall_inc = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable_i && |ch_valid_i) begin
               if (full_w) begin
                  stall_inc = 1'b1;
               end else begin
                  push    = 1'b1;
                  state_d = ST_WAIT;
               end
            end
         end
         // Hold off until the granted channel drops its stale valid.
         ST_WAIT: if (!ch_valid_i[last_q]) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q  <= ST_IDLE;
         last_q   <= CHAN_W'(NCHAN - 1);
         ack_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         stall_q  <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         if (push) begin
            last_q   <= winner;
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: ;
         endcase
         if (stall_inc && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (push) mem[wr_ptr_q] <= {winner, win_ts};
   end

   assign head         = mem[rd_ptr_q];
   assign rd_ts_o      = empty_w ? '0 : head[TS_W-1:0];
   assign rd_chan_o    = empty_w ? '0 : head[CHAN_W+TS_W-1:TS_W];
   assign ch_ack_o     = ack_q;
   assign fifo_empty_o = empty_w;
   assign fifo_full_o  = full_w;
   assign fifo_level_o = level_q;
   assign stall_cnt_o  = stall_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_tdc_readout_sched.sv
// Bench for tdc_readout_sched: directed scenarios plus random traffic, all checked every
// cycle against a queue-based transaction model of the scheduler.
module tb_tdc_readout_sched;
   localparam int NCHAN  = 4;
   localparam int TS_W   = 32;
   localparam int DEPTH  = 8;
   localparam int CHAN_W = 2;
   localparam int LVL_W  = 4;
   localparam int W      = CHAN_W + TS_W;

   logic                  clk, rst, enable, rd_en;
   logic [NCHAN-1:0]      ch_valid;
   logic [NCHAN*TS_W-1:0] ch_ts;
   logic [NCHAN-1:0]      ch_ack_o;
   logic [TS_W-1:0]       rd_ts_o;
   logic [CHAN_W-1:0]     rd_chan_o;
   logic                  fifo_empty_o, fifo_full_o, dbg_state_o;
   logic [LVL_W-1:0]      fifo_level_o;
   logic [15:0]           stall_cnt_o;

   tdc_readout_sched #(.NCHAN(NCHAN), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .enable_i(enable), .ch_valid_i(ch_valid),
      .ch_ts_i(ch_ts), .ch_ack_o(ch_ack_o), .rd_en_i(rd_en), .rd_ts_o(rd_ts_o),
      .rd_chan_o(rd_chan_o), .fifo_empty_o(fifo_empty_o), .fifo_full_o(fifo_full_o),
      .fifo_level_o(fifo_level_o), .stall_cnt_o(stall_cnt_o), .dbg_state_o(dbg_state_o)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // scoreboard counters
   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: FIFO contents as a queue, grant = next valid channel after the last one.
   logic [W-1:0]     exp_q[$];
   bit               m_busy;
   int               m_last;
   logic [NCHAN-1:0] m_ack;
   int               m_stall;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         m_busy  = 1'b0;
         m_last  = NCHAN - 1;
         m_ack   = '0;
         m_stall = 0;
      end else begin
         bit full, pop, grant;
         int win;
         full  = (exp_q.size() == DEPTH);
         pop   = rd_en && (exp_q.size() != 0);
         grant = 1'b0;
         win   = 0;
         m_ack = '0;
         if (!m_busy) begin
            if (enable && (ch_valid != '0)) begin
               if (full) begin
                  if (m_stall < 65535) m_stall = m_stall + 1;
               end else begin
                  for (int k = 1; k <= NCHAN; k++) begin
                     if (!grant && ch_valid[(m_last + k) % NCHAN]) begin
                        grant = 1'b1;
                        win   = (m_last + k) % NCHAN;
                     end
                  end
               end
            end
         end else if (!ch_valid[m_last]) begin
            m_busy = 1'b0;
         end
         if (pop) void'(exp_q.pop_front());
         if (grant) begin
            exp_q.push_back({CHAN_W'(win), ch_ts[win*TS_W +: TS_W]});
            m_ack[win] = 1'b1;
            m_busy     = 1'b1;
            m_last     = win;
         end
      end
   end

   // Per-cycle compare, on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         chk("ack", ch_ack_o, m_ack);
         chk("state", dbg_state_o, m_busy);
         chk("empty", fifo_empty_o, exp_q.size() == 0);
         chk("full", fifo_full_o, exp_q.size() == DEPTH);
         chk("level", fifo_level_o, exp_q.size());
         chk("stall", stall_cnt_o, m_stall);
         if (exp_q.size() != 0) begin
            chk("rd_chan", rd_chan_o, exp_q[0][W-1:TS_W]);
            chk("rd_ts", rd_ts_o, exp_q[0][TS_W-1:0]);
         end
      end
   end

   // driver tasks
   logic [NCHAN-1:0] active;
   int               wait_c [NCHAN];
   int               rearm_min, rearm_max;

   task automatic cycle();
      @(posedge clk);
      #2;
   endtask

   // Channel emulator: drop valid on ack, recapture a fresh timestamp after a delay.
   task automatic chan_step();
      for (int i = 0; i < NCHAN; i++) begin
         if (active[i]) begin
            if (ch_ack_o[i]) begin
               ch_valid[i] = 1'b0;
               wait_c[i]   = $urandom_range(rearm_min, rearm_max);
            end else if (!ch_valid[i]) begin
               if (wait_c[i] == 0) begin
                  ch_valid[i]             = 1'b1;
                  ch_ts[i*TS_W +: TS_W]   = $urandom();
               end else begin
                  wait_c[i] = wait_c[i] - 1;
               end
            end
         end
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_ack"}, ch_ack_o, 4'b0000);
      chk({tag, "_rd_ts"}, rd_ts_o, 32'h0);
      chk({tag, "_rd_chan"}, rd_chan_o, 2'd0);
      chk({tag, "_empty"}, fifo_empty_o, 1'b1);
      chk({tag, "_full"}, fifo_full_o, 1'b0);
      chk({tag, "_level"}, fifo_level_o, 4'd0);
      chk({tag, "_stall"}, stall_cnt_o, 16'd0);
      chk({tag, "_state"}, dbg_state_o, 1'b0);
   endtask

   int n_ack;
   int order[$];

   initial begin
      rst = 1'b0; enable = 1'b0; rd_en = 1'b0; ch_valid = '0; ch_ts = '0; active = '0;
      rearm_min = 0; rearm_max = 0;
      for (int i = 0; i < NCHAN; i++) wait_c[i] = 0;
      #3 rst = 1'b1;
      repeat (2) cycle();
      check_reset_values("por");
      rst = 1'b0;

      // single grant on channel 2
      enable = 1'b1;
      ch_valid = 4'b0100;
      ch_ts[2*TS_W +: TS_W] = 32'h0000_1234;
      cycle();
      chk("t2_ack", ch_ack_o, 4'b0100);
      chk("t2_chan", rd_chan_o, 2'd2);
      chk("t2_ts", rd_ts_o, 32'h0000_1234);
      chk("t2_level", fifo_level_o, 4'd1);
      ch_valid = '0;
      cycle();
      chk("t2_ack_gone", ch_ack_o, 4'b0000);
      rd_en = 1'b1;
      cycle();
      rd_en = 1'b0;
      chk("t2_empty", fifo_empty_o, 1'b1);

      // reset mid-clock while in WAIT, then re-grant of the held channel
      ch_valid = 4'b0001;
      ch_ts[0 +: TS_W] = 32'hAAAA_0001;
      cycle();
      cycle();
      #1 rst = 1'b1;
      #1 check_reset_values("mid_rst");
      cycle();
      rst = 1'b0;
      cycle();
      chk("t6_ack", ch_ack_o, 4'b0001);
      chk("t6_level", fifo_level_o, 4'd1);
      chk("t6_ts", rd_ts_o, 32'hAAAA_0001);
      ch_valid = '0;
      cycle();
      rd_en = 1'b1;
      cycle();
      rd_en = 1'b0;
      chk("t6_empty", fifo_empty_o, 1'b1);

      // fill the FIFO from channel 0 with no pops
      active = 4'b0001; rearm_min = 0; rearm_max = 0;
      ch_valid[0] = 1'b1;
      ch_ts[0 +: TS_W] = $urandom();
      n_ack = 0;
      repeat (30) begin
         cycle();
         if (ch_ack_o[0]) n_ack++;
         chan_step();
      end
      chk("t4_acks", n_ack, 8);
      chk("t4_full", fifo_full_o, 1'b1);
      chk("t4_level", fifo_level_o, 4'd8);
      chk("t4_stall", stall_cnt_o, 16'd14);
      rd_en = 1'b1;
      cycle();
      chan_step();
      rd_en = 1'b0;
      chk("t4_pop_level", fifo_level_o, 4'd7);
      chk("t4_pop_ack", ch_ack_o, 4'b0000);
      chk("t4_pop_stall", stall_cnt_o, 16'd15);
      cycle();
      chk("t4_ack9", ch_ack_o, 4'b0001);
      chk("t4_full9", fifo_full_o, 1'b1);
      chan_step();
      active = '0;
      rd_en = 1'b1;
      repeat (5) cycle();
      rd_en = 1'b0;
      chk("t5_pre_level", fifo_level_o, 4'd3);

      // concurrent push and pop at level 3
      ch_valid[1] = 1'b1;
      ch_ts[1*TS_W +: TS_W] = $urandom();
      rd_en = 1'b1;
      cycle();
      rd_en = 1'b0;
      chk("t5_level", fifo_level_o, 4'd3);
      chk("t5_ack", ch_ack_o, 4'b0010);
      ch_valid[1] = 1'b0;
      cycle();
      rd_en = 1'b1;
      repeat (3) cycle();
      rd_en = 1'b0;
      chk("t5_empty", fifo_empty_o, 1'b1);

      // fairness with all channels busy
      #1 rst = 1'b1;
      cycle();
      rst = 1'b0;
      active = '1; rearm_min = 2; rearm_max = 2;
      for (int i = 0; i < NCHAN; i++) begin
         ch_ts[i*TS_W +: TS_W] = $urandom();
         wait_c[i] = 0;
      end
      ch_valid = '1;
      rd_en = 1'b1;
      repeat (20) begin
         cycle();
         for (int i = 0; i < NCHAN; i++) if (ch_ack_o[i]) order.push_back(i);
         chan_step();
      end
      chk("t3_grants", order.size() >= 8, 1'b1);
      for (int i = 0; i < order.size() && i < 8; i++) chk("t3_order", order[i], i % NCHAN);

      // random traffic
      rearm_min = 0; rearm_max = 6;
      for (int c = 0; c < 3000; c++) begin
         rd_en  = ($urandom_range(0, 99) < 40);
         enable = ($urandom_range(0, 99) < 90);
         cycle();
         chan_step();
         if ($urandom_range(0, 499) == 0) begin
            #1 rst = 1'b1;
            cycle();
            rst = 1'b0;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
